// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, flag vector type, opcodes and the
// occupancy states of the 2-entry result FIFO.
package alu_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] alu_flags_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;

    // The encoding doubles as the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic alu_flags_t pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        alu_flags_t f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_fifo2.sv
// Generic 2-entry valid/ready FIFO. in_ready is registered and out_valid comes
// straight from occupancy, so nothing passes combinationally from in to out.
module alu_result_fifo2
    import alu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          pop
);

    occ_e          r_occ;
    occ_e          w_occ_nxt;
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic          r_in_ready;
    logic [DW-1:0] r_mem [2];
    logic          w_push;
    logic          w_pop;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_occ != OCC_EMPTY) && out_ready;

    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            OCC_EMPTY: if (w_push) w_occ_nxt = OCC_ONE;
            OCC_ONE: begin
                if (w_push && !w_pop)      w_occ_nxt = OCC_FULL;
                else if (w_pop && !w_push) w_occ_nxt = OCC_EMPTY;
            end
            OCC_FULL:  if (w_pop) w_occ_nxt = OCC_ONE;
            default:   w_occ_nxt = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= OCC_EMPTY;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_occ      <= w_occ_nxt;
            r_in_ready <= (w_occ_nxt != OCC_FULL);
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_occ != OCC_EMPTY);
    // Gating keeps the head at zero out of reset without resetting storage.
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign pop       = w_pop;

endmodule

// File: rtl/alu_result_stage.sv
// Registered result/flag capture stage behind the ALU: 2-entry FIFO, sticky NZCV,
// delivered-result counter. Optional macro ALU_ZERO_CHECK_EN builds the zero-flag check.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OPW   = 4,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_cout,
    input  logic             in_overflow,
    input  logic             in_negative,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPW-1:0]   out_opcode,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       out_flags,
    input  logic             sticky_clr,
    output logic [3:0]       sticky_flags,
    output logic [CNTW-1:0]  result_cnt,
    output logic             flag_err
);

    localparam int DW = OPW + WIDTH + 4;

    logic [DW-1:0]   w_in_data;
    logic [DW-1:0]   w_out_data;
    logic            w_pop;
    alu_flags_t      w_in_flags;
    alu_flags_t      r_sticky;
    logic [CNTW-1:0] r_cnt;

    assign w_in_flags = pack_flags(in_negative, in_zero, in_cout, in_overflow);
    assign w_in_data  = {in_opcode, in_y, w_in_flags};

    alu_result_fifo2 #(.DW(DW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data),
        .pop       (w_pop)
    );

    assign {out_opcode, out_y, out_flags} = w_out_data;

    // Clear-then-accumulate when sticky_clr coincides with a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_pop) begin
                r_sticky <= (sticky_clr ? 4'b0000 : r_sticky) | out_flags;
                r_cnt    <= r_cnt + CNTW'(1);
            end else if (sticky_clr) begin
                r_sticky <= '0;
            end
        end
    end

    assign sticky_flags = r_sticky;
    assign result_cnt   = r_cnt;

`ifdef ALU_ZERO_CHECK_EN
    logic w_push;
    logic w_mismatch;
    logic r_flag_err;

    assign w_push     = in_valid && in_ready;
    assign w_mismatch = in_zero != (in_y == '0);

    always_ff @(posedge clk) begin
        if (rst)                         r_flag_err <= 1'b0;
        else if (sticky_clr)             r_flag_err <= 1'b0;
        else if (w_push && w_mismatch)   r_flag_err <= 1'b1;
    end

    assign flag_err = r_flag_err;
`else
    assign flag_err = 1'b0;
`endif

endmodule
